if_id_queue: RTL
================

// Module: if_id_queue
// PURPOSE
// - Instruction queue between the fetch stage and the decode stage of the pipelined core.
// - Buffers {PC, instruction} pairs from fetch so decode stalls do not lose fetched words.
// - Flushed on a taken branch: wrong-path instructions are discarded and fetch refills from the new PC.
// - In-order FIFO with valid/ready handshakes on both sides and registered storage.
// PARAMETERS
// - DEPTH    4   number of entries; legal range 2..16, any value (not restricted to powers of 2)
// - PC_W     32  PC width; the PC is word-addressed (sequential PC advances by 1)
// - INSTR_W  32  instruction width
// PORTS
// - clk        in   1                   clock; all state updates on the posedge
// - rst        in   1                   reset; synchronous, active-high
// - flush      in   1                   taken branch; discards all queued and incoming entries
// - in_valid   in   1                   fetch presents a valid {in_pc, in_instr}
// - in_ready   out  1                   queue can accept a push this cycle
// - in_pc      in   PC_W                PC of the fetched instruction
// - in_instr   in   INSTR_W             fetched instruction word
// - out_valid  out  1                   head entry is valid for decode
// - out_ready  in   1                   decode consumes the head entry this cycle
// - out_pc     out  PC_W                PC of the head entry
// - out_instr  out  INSTR_W             instruction of the head entry
// - count      out  $clog2(DEPTH+1)     number of occupied entries
// BEHAVIOUR
// - State: storage array[DEPTH] of {pc, instr}; wr_ptr, rd_ptr (range 0..DEPTH-1); count register.
// - push = in_valid & in_ready; pop = out_valid & out_ready.
// - in_ready = (count != DEPTH) & ~flush. It depends only on count and flush, never on out_ready.
//   - A push is therefore refused when the queue is full, even if a pop happens in the same cycle.
// - out_valid = (count != 0).
// - out_pc/out_instr = array[rd_ptr] when out_valid; both are forced to 0 when ~out_valid (0 = NOP).
// - Latency: a pushed entry is visible on out_* on the cycle after the push; there is no same-cycle fall-through.
// - Pointer update: on push, array[wr_ptr] <= {in_pc, in_instr} and wr_ptr advances. On pop, rd_ptr advances.
//   - Both pointers wrap from DEPTH-1 to 0 by explicit compare, not modulo-2^n.
// - Count update:
//   - push & ~pop -> count+1
//   - pop & ~push -> count-1
//   - push & pop  -> count unchanged (only legal when 0 < count < DEPTH)
// - Order: strictly FIFO; entries leave in push order across pointer wrap.
// - Flush (priority over push/pop): next cycle wr_ptr = rd_ptr = 0, count = 0.
//   - A same-cycle push is discarded. A same-cycle pop is irrelevant. out_valid = 0 next cycle.
// - rst (highest priority, also mid-operation): wr_ptr = rd_ptr = 0, count = 0.
//   - Resulting outputs: out_valid = 0, out_pc = 0, out_instr = 0, in_ready = 1.
//   - Storage array is not reset; it is masked by out_valid.
// - Empty: pop cannot occur (out_valid = 0); out_ready is ignored.
// - Full: in_ready = 0; in_valid is ignored and in_* are not written.
// - No combinational path from out_ready to in_ready, or from in_valid to out_valid.
// TESTING (DEPTH=4)
// - Reset: assert rst 2 cycles, deassert -> out_valid=0, count=0, in_ready=1, out_pc=0, out_instr=0.
// - Fill/full: out_ready=0, push PC 0..3 / instr 0xA0..0xA3.
//   - Expect count=4 and in_ready=0 after the 4th push; a 5th push (PC 4) is ignored.
//   - Then out_ready=1: drain yields PC 0,1,2,3 in order, then out_valid=0.
// - Simultaneous push+pop: at count=2, push PC 7 with out_ready=1 every cycle for 6 cycles.
//   - Expect count held at 2 and outputs in exact push order.
// - Wrap-around: interleave 10 single pushes/pops so both pointers wrap twice.
//   - Every out_pc/out_instr matches its pushed value in order; count never exceeds 4.
// - Flush: count=3, assert flush together with a push of PC 9.
//   - Next cycle count=0, out_valid=0, in_ready=1; PC 9 never appears on out_pc.
// - Reset mid-operation: count=3 with a push and pop pending, assert rst.
//   - Next cycle empty, outputs zero; a following push of PC 0x20 appears at out_pc one cycle later.

Source files
------------

// File: rtl/if_id_queue_if.sv
// ---------------------------------------------------------------------------
// if_id_queue_if
// Bundle of the fetch-side and decode-side signals of the IF/ID queue.
//   master : the pipeline side. It drives flush, the fetch push (in_valid,
//            in_pc, in_instr) and the decode pop (out_ready). It sees
//            in_ready, the head entry (out_valid, out_pc, out_instr) and count.
//   slave  : the queue itself, with the opposite directions.
// ---------------------------------------------------------------------------
interface if_id_queue_if #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [CNT_W-1:0]   count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
// In-order instruction queue between fetch and decode. It holds {PC, instr}
// pairs so that a decode stall does not drop fetched words. A taken branch
// (flush) empties the queue in one cycle.
// Ports:
//   clk   - clock; all state changes on the rising edge
//   rst   - synchronous, active-high reset (pointers and count only)
//   q     - if_id_queue_if.slave:
//           flush                        discard queued and incoming entries
//           in_valid/in_ready/in_pc/in_instr     push side (fetch)
//           out_valid/out_ready/out_pc/out_instr pop side (decode)
//           count                        number of occupied entries
// DEPTH may be any value in 2..16. The pointers wrap by explicit compare,
// so DEPTH does not have to be a power of two.
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  q
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    // The storage has no reset. Stale contents are hidden by out_valid.
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;

    // in_ready looks only at count and flush. A full queue therefore refuses
    // a push even when decode pops in the same cycle. This keeps out_ready
    // out of the fetch-side timing path.
    assign in_ready  = (count_q != CNT_W'(DEPTH)) && !q.flush;
    assign out_valid = (count_q != '0);
    assign push      = q.in_valid && in_ready;
    assign pop       = out_valid && q.out_ready;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            // A push cannot happen here because in_ready is low. Any pop
            // is overridden, since everything is discarded anyway.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)
                count_d = count_q + CNT_W'(1);
            else if (pop && !push)
                count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr_q]    <= q.in_pc;
            instr_mem[wr_ptr_q] <= q.in_instr;
        end
    end

    assign q.in_ready  = in_ready;
    assign q.out_valid = out_valid;
    // An empty queue presents 0 on both fields, which decode treats as a NOP.
    assign q.out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
    assign q.out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
    assign q.count     = count_q;
endmodule
